// File: rtl/reg_pull2_pkg.sv
// rtl/reg_pull2_pkg.sv - occupancy encoding and protocol helpers for reg_pull2
package reg_pull2_pkg;

  // Occupancy is the pair {v1, v0}; v1 without v0 never occurs.
  localparam logic [1:0] OCC_EMPTY = 2'b00;
  localparam logic [1:0] OCC_ONE   = 2'b01;
  localparam logic [1:0] OCC_FULL  = 2'b11;

  function automatic logic [1:0] occ_of(input logic v0, input logic v1);
    return {v1, v0};
  endfunction

  function automatic logic is_violation(input logic [1:0] occ, input logic enq,
                                        input logic deq);
    return (enq && (occ == OCC_FULL)) || (deq && (occ == OCC_EMPTY));
  endfunction

endpackage

// File: rtl/reg_pull2.sv
// rtl/reg_pull2.sv - two-entry registered buffer with reader-side pull handshake
module reg_pull2
  import reg_pull2_pkg::*;
#(
  parameter int               width = 1,
  parameter logic [width-1:0] init  = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [width-1:0] D_IN,
  input  logic             ENQ,
  output logic             FULL_N,
  input  logic             DEQ,
  output logic             EMPTY_N,
  output logic [width-1:0] D_OUT,
  input  logic             CLR,
  output logic             ERR
);

  logic [width-1:0] r_d0;
  logic [width-1:0] r_d1;
  logic             r_v0;
  logic             r_v1;
  logic             r_err;

  logic [1:0]       w_occ;
  logic [width-1:0] w_d0_nxt;
  logic [width-1:0] w_d1_nxt;
  logic             w_v0_nxt;
  logic             w_v1_nxt;
  logic             w_err_nxt;

  assign w_occ = occ_of(r_v0, r_v1);

  always_comb begin
    w_d0_nxt  = r_d0;
    w_d1_nxt  = r_d1;
    w_v0_nxt  = r_v0;
    w_v1_nxt  = r_v1;
    w_err_nxt = r_err | is_violation(w_occ, ENQ, DEQ);

    case (w_occ)
      OCC_EMPTY: begin
        if (ENQ) begin
          w_v0_nxt = 1'b1;
          w_d0_nxt = D_IN;
        end
      end
      OCC_ONE: begin
        case ({ENQ, DEQ})
          2'b10: begin
            w_v1_nxt = 1'b1;
            w_d1_nxt = D_IN;
          end
          2'b01:   w_v0_nxt = 1'b0;
          2'b11:   w_d0_nxt = D_IN;
          default: ;
        endcase
      end
      OCC_FULL: begin
        // An ENQ while full is dropped; only the pull is acted on.
        if (DEQ) begin
          w_v1_nxt = 1'b0;
          w_d0_nxt = r_d1;
        end
      end
      default: begin
        w_v0_nxt = 1'b0;
        w_v1_nxt = 1'b0;
      end
    endcase

    if (CLR) begin
      w_d0_nxt  = init;
      w_d1_nxt  = init;
      w_v0_nxt  = 1'b0;
      w_v1_nxt  = 1'b0;
      w_err_nxt = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_d0  <= init;
      r_d1  <= init;
      r_v0  <= 1'b0;
      r_v1  <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_d0  <= w_d0_nxt;
      r_d1  <= w_d1_nxt;
      r_v0  <= w_v0_nxt;
      r_v1  <= w_v1_nxt;
      r_err <= w_err_nxt;
    end
  end

  assign EMPTY_N = r_v0;
  assign FULL_N  = ~r_v1;
  assign D_OUT   = r_d0;
  assign ERR     = r_err;

endmodule
